// File: rtl/aes_core_arbiter_if.sv
// Handshake bundle between the arbiter, its two requesters, the shared AES core and the response sink.
// master = arbiter side; slave = requesters, core and response consumer.
interface aes_core_arbiter_if;
    logic         i_req0_valid;
    logic         i_req1_valid;
    logic         o_req0_ready;
    logic         o_req1_ready;
    logic [0:127] i_req0_key;
    logic [0:127] i_req1_key;
    logic [0:127] i_req0_block;
    logic [0:127] i_req1_block;

    logic         o_core_key_load;
    logic [0:127] o_core_key;
    logic         i_core_key_done;
    logic         o_core_start;
    logic [0:127] o_core_block;
    logic         i_core_done;
    logic [0:127] i_core_result;

    logic         o_rsp_valid;
    logic         i_rsp_ready;
    logic         o_rsp_id;
    logic [0:127] o_rsp_data;
    logic         o_rsp_err;
    logic         o_busy;

    modport master (
        input  i_req0_valid, i_req1_valid, i_req0_key, i_req1_key, i_req0_block, i_req1_block,
        output o_req0_ready, o_req1_ready,
        output o_core_key_load, o_core_key, o_core_start, o_core_block,
        input  i_core_key_done, i_core_done, i_core_result,
        output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err, o_busy,
        input  i_rsp_ready
    );

    modport slave (
        output i_req0_valid, i_req1_valid, i_req0_key, i_req1_key, i_req0_block, i_req1_block,
        input  o_req0_ready, o_req1_ready,
        input  o_core_key_load, o_core_key, o_core_start, o_core_block,
        output i_core_key_done, i_core_done, i_core_result,
        input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err, o_busy,
        output i_rsp_ready
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES-128 core between two requesters, with a one-entry expanded-key cache.
// Key hit: core start one cycle after accept; response held until i_rsp_ready, no accept until then.
module aes_core_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               i_reset_n,
    aes_core_arbiter_if.master bus
);

    localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_LOAD,
        S_KEY_WAIT,
        S_START,
        S_WAIT,
        S_RESP
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [0:127]  key_q;
    logic [0:127]  block_q;
    logic [0:127]  cache_key_q;
    logic [0:127]  rsp_data_q;
    logic          id_q;
    logic          last_q;
    logic          cache_vld_q;
    logic          rsp_err_q;
    logic [TW-1:0] tmo_q;

    logic          gnt_any;
    logic          gnt_id;
    logic          xfer;
    logic [0:127]  xfer_key;
    logic [0:127]  xfer_block;
    logic          key_hit;
    logic          key_done_ev;
    logic          core_done_ev;
    logic          tmo_abort;
    logic          rsp_hs;

    // On a tie the requester not served last wins; last_q resets to 1 so requester 0 wins first.
    always_comb begin
        gnt_any      = bus.i_req0_valid | bus.i_req1_valid;
        gnt_id       = (bus.i_req0_valid & bus.i_req1_valid) ? ~last_q : bus.i_req1_valid;
        xfer_key     = gnt_id ? bus.i_req1_key : bus.i_req0_key;
        xfer_block   = gnt_id ? bus.i_req1_block : bus.i_req0_block;
        xfer         = i_reset_n & (state_q == S_IDLE) & gnt_any;
        key_hit      = cache_vld_q & (cache_key_q == xfer_key);
        key_done_ev  = (state_q == S_KEY_WAIT) & bus.i_core_key_done;
        core_done_ev = (state_q == S_WAIT) & bus.i_core_done;
        tmo_abort    = (tmo_q == TMO_LAST) &
                       (((state_q == S_KEY_WAIT) & ~bus.i_core_key_done) |
                        ((state_q == S_WAIT) & ~bus.i_core_done));
        rsp_hs       = (state_q == S_RESP) & bus.i_rsp_ready;
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d = key_hit ? S_START : S_KEY_LOAD;
                end
            end
            S_KEY_LOAD: state_d = S_KEY_WAIT;
            S_KEY_WAIT: begin
                if (bus.i_core_key_done) begin
                    state_d = S_START;
                end else if (tmo_abort) begin
                    state_d = S_RESP;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.i_core_done || tmo_abort) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_req0_ready    = xfer & ~gnt_id;
        bus.o_req1_ready    = xfer & gnt_id;
        bus.o_core_key_load = (state_q == S_KEY_LOAD);
        bus.o_core_start    = (state_q == S_START);
        bus.o_rsp_valid     = (state_q == S_RESP);
        bus.o_busy          = (state_q != S_IDLE);
    end

    assign bus.o_core_key   = key_q;
    assign bus.o_core_block = block_q;
    assign bus.o_rsp_id     = id_q;
    assign bus.o_rsp_data   = rsp_data_q;
    assign bus.o_rsp_err    = rsp_err_q;

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            key_q       <= '0;
            block_q     <= '0;
            cache_key_q <= '0;
            rsp_data_q  <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            cache_vld_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            tmo_q       <= '0;
        end else begin
            if (xfer) begin
                key_q   <= xfer_key;
                block_q <= xfer_block;
                id_q    <= gnt_id;
            end
            // KEY_LOAD and START are the only predecessors of the two waiting states.
            if (state_q == S_KEY_LOAD || state_q == S_START) begin
                tmo_q <= '0;
            end else if (state_q == S_KEY_WAIT || state_q == S_WAIT) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (key_done_ev) begin
                cache_key_q <= key_q;
                cache_vld_q <= 1'b1;
            end
            if (core_done_ev) begin
                rsp_data_q <= bus.i_core_result;
                rsp_err_q  <= 1'b0;
            end else if (tmo_abort) begin
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
                cache_vld_q <= 1'b0;
            end
            if (rsp_hs) begin
                last_q <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter: FIPS-197 vector, key caching, round-robin, timeout, stall, reset abort.
`timescale 1ns/1ps
module tb_aes_core_arbiter;

    localparam logic [0:127] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_core_arbiter_if ifc ();

    aes_core_arbiter #(.TIMEOUT_CYCLES(64)) dut (
        .clk       (clk),
        .i_reset_n (rst_n),
        .bus       (ifc)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int both_rdy    = 0;
    int kl_cnt      = 0;
    int st_cnt      = 0;
    int start_cyc   = 0;
    int kcnt        = 0;
    int dcnt        = 0;
    bit mute_done   = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.o_req0_ready && ifc.o_req1_ready) both_rdy <= both_rdy + 1;
    end

    // Core model: key expansion done 3 cycles after key_load, encryption done 2 cycles after start.
    always @(negedge clk) begin
        ifc.i_core_key_done = 1'b0;
        ifc.i_core_done     = 1'b0;
        if (ifc.o_core_key_load) begin
            kl_cnt++;
            kcnt = 3;
        end else if (kcnt > 0) begin
            kcnt--;
            if (kcnt == 0) ifc.i_core_key_done = 1'b1;
        end
        if (ifc.o_core_start) begin
            st_cnt++;
            start_cyc = cyc;
            dcnt = 2;
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0 && !mute_done) ifc.i_core_done = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic submit(input bit id, input logic [0:127] key, input logic [0:127] blk,
                          output int xfer_cyc);
        int n;
        if (id) begin
            ifc.i_req1_valid = 1'b1;
            ifc.i_req1_key   = key;
            ifc.i_req1_block = blk;
        end else begin
            ifc.i_req0_valid = 1'b1;
            ifc.i_req0_key   = key;
            ifc.i_req0_block = blk;
        end
        #1;
        n = 0;
        while (!(id ? ifc.o_req1_ready : ifc.o_req0_ready) && n < 50) begin
            tick();
            #1;
            n++;
        end
        check("xfer_wait", 128'(n < 50), 128'(1));
        xfer_cyc = cyc;
        tick();
        ifc.i_req0_valid = 1'b0;
        ifc.i_req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rsp_cyc);
        int n;
        n = 0;
        while (!ifc.o_rsp_valid && n < 300) begin
            tick();
            n++;
        end
        check("rsp_wait", 128'(n < 300), 128'(1));
        rsp_cyc = cyc;
    endtask

    task automatic finish_rsp();
        ifc.i_rsp_ready = 1'b1;
        tick();
        ifc.i_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, r, kl0, st0, bad;
        rst_n            = 1'b0;
        ifc.i_req0_valid = 1'b0;
        ifc.i_req1_valid = 1'b0;
        ifc.i_req0_key   = '0;
        ifc.i_req1_key   = '0;
        ifc.i_req0_block = '0;
        ifc.i_req1_block = '0;
        ifc.i_rsp_ready  = 1'b0;
        ifc.i_core_result = CT_A;

        // Reset state, including a requester already valid while reset is held.
        tick();
        tick();
        ifc.i_req0_valid = 1'b1;
        #1;
        check("rst_ready0", 128'(ifc.o_req0_ready), 128'(0));
        check("rst_busy", 128'(ifc.o_busy), 128'(0));
        check("rst_rsp_valid", 128'(ifc.o_rsp_valid), 128'(0));
        check("rst_key_load", 128'(ifc.o_core_key_load), 128'(0));
        check("rst_start", 128'(ifc.o_core_start), 128'(0));
        check("rst_core_key", ifc.o_core_key, 128'(0));
        check("rst_rsp_err", 128'(ifc.o_rsp_err), 128'(0));
        ifc.i_req0_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // FIPS-197 vector from requester 0, cold cache.
        kl0 = kl_cnt;
        st0 = st_cnt;
        submit(1'b0, KEY_A, PT_A, t);
        check("a_key_load", 128'(ifc.o_core_key_load), 128'(1));
        check("a_core_key", ifc.o_core_key, KEY_A);
        check("a_busy", 128'(ifc.o_busy), 128'(1));
        wait_rsp(r);
        check("a_kl_count", 128'(kl_cnt - kl0), 128'(1));
        check("a_st_count", 128'(st_cnt - st0), 128'(1));
        check("a_core_block", ifc.o_core_block, PT_A);
        check("a_rsp_id", 128'(ifc.o_rsp_id), 128'(0));
        check("a_rsp_data", ifc.o_rsp_data, CT_A);
        check("a_rsp_err", 128'(ifc.o_rsp_err), 128'(0));
        finish_rsp();
        check("a_idle_busy", 128'(ifc.o_busy), 128'(0));

        // Same key from requester 1: cache hit, start the cycle after transfer.
        kl0 = kl_cnt;
        submit(1'b1, KEY_A, PT_A, t);
        wait_rsp(r);
        check("b_kl_count", 128'(kl_cnt - kl0), 128'(0));
        check("b_start_cyc", 128'(start_cyc), 128'(t + 1));
        check("b_rsp_cyc", 128'(r), 128'(t + 4));
        check("b_rsp_id", 128'(ifc.o_rsp_id), 128'(1));
        check("b_rsp_data", ifc.o_rsp_data, CT_A);
        finish_rsp();

        // Both requesters valid continuously: last served was 1, so 0,1,0,1.
        ifc.i_req0_key   = KEY_A;
        ifc.i_req1_key   = KEY_A;
        ifc.i_req0_block = PT_A;
        ifc.i_req1_block = PT_A;
        ifc.i_req0_valid = 1'b1;
        ifc.i_req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!(ifc.o_req0_ready || ifc.o_req1_ready) && n < 50) begin
                tick();
                #1;
                n++;
            end
            check("rr_wait", 128'(n < 50), 128'(1));
            check("rr_grant", 128'(ifc.o_req1_ready), 128'(i % 2));
            tick();
            wait_rsp(r);
            check("rr_rsp_id", 128'(ifc.o_rsp_id), 128'(i % 2));
            finish_rsp();
            #1;
        end
        ifc.i_req0_valid = 1'b0;
        ifc.i_req1_valid = 1'b0;
        tick();

        // Core never signals done: 64 WAIT cycles then error response; cache is dropped.
        mute_done = 1'b1;
        kl0 = kl_cnt;
        submit(1'b0, KEY_A, PT_A, t);
        wait_rsp(r);
        check("to_kl_count", 128'(kl_cnt - kl0), 128'(0));
        check("to_wait_len", 128'(r - start_cyc), 128'(65));
        check("to_rsp_err", 128'(ifc.o_rsp_err), 128'(1));
        check("to_rsp_data", ifc.o_rsp_data, 128'(0));
        finish_rsp();
        mute_done = 1'b0;
        kl0 = kl_cnt;
        submit(1'b0, KEY_A, PT_A, t);
        wait_rsp(r);
        check("to_reload_kl", 128'(kl_cnt - kl0), 128'(1));
        check("to_reload_err", 128'(ifc.o_rsp_err), 128'(0));
        check("to_reload_data", ifc.o_rsp_data, CT_A);
        finish_rsp();

        // Response consumer stalls 10 cycles while requester 0 is waiting.
        ifc.i_core_result = CT_B;
        submit(1'b1, KEY_B, PT_B, t);
        wait_rsp(r);
        check("st_rsp_data", ifc.o_rsp_data, CT_B);
        check("st_rsp_id", 128'(ifc.o_rsp_id), 128'(1));
        ifc.i_req0_key   = KEY_B;
        ifc.i_req0_block = PT_B;
        ifc.i_req0_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            if (!ifc.o_rsp_valid || ifc.o_rsp_data !== CT_B || ifc.o_rsp_id !== 1'b1 ||
                ifc.o_req0_ready || ifc.o_req1_ready) bad++;
        end
        check("st_hold_bad", 128'(bad), 128'(0));
        ifc.i_rsp_ready = 1'b1;
        tick();
        ifc.i_rsp_ready = 1'b0;
        #1;
        check("st_rel_busy", 128'(ifc.o_busy), 128'(0));
        check("st_rel_valid", 128'(ifc.o_rsp_valid), 128'(0));
        check("st_rel_ready0", 128'(ifc.o_req0_ready), 128'(1));
        ifc.i_req0_valid = 1'b0;
        tick();

        // Reset pulse in the first WAIT cycle; the core's done lands one cycle later.
        submit(1'b0, KEY_B, PT_B, t);
        check("rs_start", 128'(ifc.o_core_start), 128'(1));
        tick();
        check("rs_busy", 128'(ifc.o_busy), 128'(1));
        rst_n = 1'b0;
        tick();
        check("rs_busy0", 128'(ifc.o_busy), 128'(0));
        check("rs_valid0", 128'(ifc.o_rsp_valid), 128'(0));
        check("rs_core_key0", ifc.o_core_key, 128'(0));
        check("rs_core_block0", ifc.o_core_block, 128'(0));
        check("rs_rsp_data0", ifc.o_rsp_data, 128'(0));
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ifc.o_rsp_valid || ifc.o_busy) bad++;
        end
        check("rs_late_done_bad", 128'(bad), 128'(0));

        // After reset: tie goes to requester 0 and the cache is empty.
        ifc.i_req0_key   = KEY_B;
        ifc.i_req1_key   = KEY_B;
        ifc.i_req0_block = PT_B;
        ifc.i_req1_block = PT_B;
        ifc.i_req0_valid = 1'b1;
        ifc.i_req1_valid = 1'b1;
        #1;
        check("pr_ready0", 128'(ifc.o_req0_ready), 128'(1));
        check("pr_ready1", 128'(ifc.o_req1_ready), 128'(0));
        kl0 = kl_cnt;
        tick();
        ifc.i_req0_valid = 1'b0;
        ifc.i_req1_valid = 1'b0;
        wait_rsp(r);
        check("pr_kl_count", 128'(kl_cnt - kl0), 128'(1));
        check("pr_rsp_id", 128'(ifc.o_rsp_id), 128'(0));
        finish_rsp();

        check("one_ready_max", 128'(both_rdy), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
